irq_controller: RTL and testbench
=================================

# irq_controller

Bus-mapped interrupt controller that merges up to eight peripheral interrupt lines (timer, mouse, etc.) onto the processor's single interrupt raise/ack pair. It captures source requests as pending bits, applies a mask, dispatches one interrupt at a time by fixed priority, and exposes the active source ID on the data bus. The processor signals end-of-interrupt by writing a bus register. Peripherals keep their existing raise-until-ack protocol.

## Interface
- `NumSources`, 4: number of source lines, 1..8; source 0 has the highest priority.
- `BaseAddr`, 8'hE0: base of the 4-byte register window.
- `InitialMask`, 8'hFF: reset value of the mask; only bits [NumSources-1:0] are used.
- `CLK`  in  1  clock
- `RESET`  in  1  synchronous, active-high
- `BUS_DATA`  inout  8  shared data bus, tristated when not read
- `BUS_ADDR`  in  8  bus address
- `BUS_WE`  in  1  bus write enable
- `SRC_IRQ_RAISE`  in  NumSources  per-source raise, held high until acked
- `SRC_IRQ_ACK`  out  NumSources  one-cycle ack pulse to the dispatched source
- `CPU_IRQ_RAISE`  out  1  interrupt request to the processor
- `CPU_IRQ_ACK`  in  1  processor acknowledge

## Operation
- Register map:
  - +0 R: Pending, zero-extended.
  - +1 R/W: Mask; a 1 enables dispatch.
  - +2 R: {InService, 4'b0, ActiveId[2:0]}.
  - +2 W: EOI; the data value is ignored.
  - +3 W: clear Pending bits wherever the data bit is 1.
- Capture: `RaiseD` is `SRC_IRQ_RAISE` registered. Pending[i] is set when `SRC_IRQ_RAISE[i] & ~RaiseD[i]`. Masked sources still capture.
- Simultaneous set and clear of the same Pending bit (dispatch or +3 write): set wins.
- FSM states are IDLE, RAISE, ACK, SERVICE.
  - IDLE: if `Pending & Mask` is non-zero, latch ActiveId as the lowest set index, clear that Pending bit, and go to RAISE.
  - RAISE: `CPU_IRQ_RAISE`=1. On `CPU_IRQ_ACK` go to ACK.
  - ACK: `SRC_IRQ_ACK[ActiveId]`=1 for exactly this cycle, `CPU_IRQ_RAISE`=0. Go to SERVICE unconditionally.
  - SERVICE: InService=1. On a write to +2, go to IDLE. No new dispatch happens while in SERVICE.
- InService is 1 in states RAISE, ACK and SERVICE.
- ActiveId changes only on dispatch, so it stays valid for the ISR until the next dispatch.
- Mask writes never retract an interrupt already in RAISE.
- `CPU_IRQ_ACK` outside RAISE is ignored.
- Bus reads: the address is registered, and `BUS_DATA` is driven during the cycle after the address is presented.
  - Drive only when that registered address is +0..+2 and `BUS_WE` is 0; otherwise 8'hZZ.
- Writes are decoded as `BUS_ADDR` match & `BUS_WE` on the clock edge.

## Timing
- Reset values:
  - Pending=0, Mask=InitialMask, ActiveId=0, state IDLE, RaiseD=0.
  - `CPU_IRQ_RAISE`=0, `SRC_IRQ_ACK`=0, `BUS_DATA`=Z.
- Request latency: raise first sampled high at edge E0 sets Pending after E0. Dispatch happens at E1, so `CPU_IRQ_RAISE`=1 after E1 (2 edges).
- Ack: `CPU_IRQ_ACK` sampled at A0 gives RAISE low and `SRC_IRQ_ACK` high after A0. `SRC_IRQ_ACK` is low again after A1.
- EOI sampled at W0 returns the FSM to IDLE. The earliest next `CPU_IRQ_RAISE` is after W1.
- Back-to-back edges on one source before dispatch collapse into one pending event.
- Reset mid-operation: everything returns to reset values and no `SRC_IRQ_ACK` is issued. A source still holding raise is re-captured one edge after reset is released, because RaiseD resets to 0.

## Structure
- Package `irq_ctrl_pkg`:
  - state enum (IDLE, RAISE, ACK, SERVICE)
  - register offset constants (OFF_PEND=0, OFF_MASK=1, OFF_ID=2, OFF_CLR=3)
  - max source count 8
- Sub-module `irq_priority_encoder`: combinational; takes `Pending & Mask` and outputs a valid flag and the 3-bit lowest set index.
- Top level holds the capture logic, registers, FSM and bus interface.

## Test plan
- Single request: source 2 raises, held until ack.
  - `CPU_IRQ_RAISE` goes high 2 edges later.
  - CPU ack causes a one-cycle `SRC_IRQ_ACK`=4'b0100.
  - Read +2 returns 8'h82.
- Priority: sources 3 and 1 raise in the same cycle.
  - Source 1 is dispatched first and Pending reads 8'h08.
  - After EOI, source 3 is dispatched, one edge after the EOI edge.
- Mask: write +1 = 8'hFE, then source 0 raises.
  - No `CPU_IRQ_RAISE` and Pending=8'h01.
  - Writing +1 = 8'hFF dispatches 2 edges later.
- Clear versus set: write +3 = 8'h02 in the same cycle that source 1's raise edge is captured.
  - Pending[1] stays 1.
- SERVICE hold: with no EOI written and another source pending, `CPU_IRQ_RAISE` stays 0 for 100 cycles.
  - ActiveId is unchanged throughout.
- Reset in RAISE: assert RESET for 1 cycle.
  - Outputs return to reset values with no `SRC_IRQ_ACK` pulse.
  - The held source raise is re-dispatched 2 edges after reset deasserts.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared types and constants for the bus-mapped interrupt controller:
//   - irq_state_e : dispatch FSM states
//   - OFF_*       : register offsets inside the 4-byte bus window
//   - MAX_SOURCES : upper bound on interrupt source lines
//   - ID_W        : width of a source index
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

    localparam int MAX_SOURCES = 8;
    localparam int ID_W        = $clog2(MAX_SOURCES);

    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_ID   = 2'd2;
    localparam logic [1:0] OFF_CLR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISE   = 2'd1,
        ACK     = 2'd2,
        SERVICE = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
// Combinational fixed-priority encoder: index 0 wins.
// Ports:
//   req_i   [N-1:0]  enabled pending requests (Pending & Mask)
//   valid_o          at least one request is set
//   idx_o   [ID_W-1:0] lowest set index (0 when nothing is set)
// -----------------------------------------------------------------------------
module irq_priority_encoder
    import irq_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] idx_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        valid_o = 1'b0;
        idx_o   = '0;
        // Walk from the top down so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Merges up to eight peripheral interrupt lines onto one CPU raise/ack pair.
// Rising edges on source lines set Pending bits; enabled pending sources are
// dispatched one at a time by fixed priority (source 0 highest). The CPU acks,
// the source gets a one-cycle ack pulse, and the CPU ends service by writing
// the EOI register.
// Ports:
//   CLK, RESET       clock, synchronous active-high reset
//   BUS_DATA [7:0]   shared data bus, driven only on register reads
//   BUS_ADDR [7:0]   bus address; window is BaseAddr..BaseAddr+3
//   BUS_WE           bus write enable
//   SRC_IRQ_RAISE    per-source request, held high until acked
//   SRC_IRQ_ACK      one-cycle ack pulse to the dispatched source
//   CPU_IRQ_RAISE    interrupt request to the processor
//   CPU_IRQ_ACK      processor acknowledge
// Register window:
//   +0 R  Pending          +1 R/W Mask
//   +2 R  {InService,0000,ActiveId}   +2 W EOI
//   +3 W  clear Pending where data bit is 1
// -----------------------------------------------------------------------------
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int         NumSources  = 4,
    parameter logic [7:0] BaseAddr    = 8'hE0,
    parameter logic [7:0] InitialMask = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  logic [7:0]      BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    input  logic [NumSources-1:0] SRC_IRQ_RAISE,
    output logic [NumSources-1:0] SRC_IRQ_ACK,
    output logic                  CPU_IRQ_RAISE,
    input  logic                  CPU_IRQ_ACK
);

    // ---------------------------------------------------------------- state
    logic [NumSources-1:0] raise_d_q;
    logic [NumSources-1:0] pend_q;
    logic [NumSources-1:0] pend_d;
    logic [7:0]            mask_q;
    logic [ID_W-1:0]       active_id_q;
    irq_state_e            state_q;
    logic                  cpu_raise_q;
    logic [NumSources-1:0] src_ack_q;
    logic                  rd_sel_q;
    logic [1:0]            rd_off_q;

    // ---------------------------------------------------------- combinational
    logic                  in_window;
    logic                  wr_mask;
    logic                  wr_eoi;
    logic                  wr_clr;
    logic [NumSources-1:0] rise;
    logic [NumSources-1:0] clr_wr;
    logic [NumSources-1:0] clr_disp;
    logic [NumSources-1:0] ack_onehot;
    logic [NumSources-1:0] enc_req;
    logic                  enc_valid;
    logic [ID_W-1:0]       enc_idx;
    logic                  dispatch;
    logic                  in_service;
    logic [7:0]            rd_data;

    // The window is 4-byte aligned, so the upper six address bits select it
    // and the lower two select the register.
    assign in_window = (BUS_ADDR[7:2] == BaseAddr[7:2]);
    assign wr_mask   = BUS_WE && in_window && (BUS_ADDR[1:0] == OFF_MASK);
    assign wr_eoi    = BUS_WE && in_window && (BUS_ADDR[1:0] == OFF_ID);
    assign wr_clr    = BUS_WE && in_window && (BUS_ADDR[1:0] == OFF_CLR);

    assign enc_req    = pend_q & mask_q[NumSources-1:0];
    assign dispatch   = (state_q == IDLE) && enc_valid;
    assign in_service = (state_q != IDLE);

    irq_priority_encoder #(
        .N (NumSources)
    ) u_prio (
        .req_i   (enc_req),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    always_comb begin
        rise       = SRC_IRQ_RAISE & ~raise_d_q;
        clr_wr     = wr_clr ? BUS_DATA[NumSources-1:0] : '0;
        clr_disp   = '0;
        ack_onehot = '0;
        for (int i = 0; i < NumSources; i++) begin
            clr_disp[i]   = dispatch && (enc_idx == ID_W'(i));
            ack_onehot[i] = (active_id_q == ID_W'(i));
        end
        // A new capture is OR-ed in after the clears, so set wins a collision.
        pend_d = (pend_q & ~(clr_wr | clr_disp)) | rise;
    end

    // --------------------------------------------- capture, mask, bus address
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RESET) begin
            raise_d_q <= '0;
            pend_q    <= '0;
            mask_q    <= InitialMask;
            rd_sel_q  <= 1'b0;
            rd_off_q  <= 2'd0;
        end else begin
            raise_d_q <= SRC_IRQ_RAISE;
            pend_q    <= pend_d;
            if (wr_mask) begin
                mask_q <= BUS_DATA;
            end
            rd_sel_q <= in_window && (BUS_ADDR[1:0] != OFF_CLR);
            rd_off_q <= BUS_ADDR[1:0];
        end
    end

    // ------------------------------------------------------- dispatch FSM
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            active_id_q <= '0;
            cpu_raise_q <= 1'b0;
            src_ack_q   <= '0;
        end else begin
            src_ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (enc_valid) begin
                        active_id_q <= enc_idx;
                        cpu_raise_q <= 1'b1;
                        state_q     <= RAISE;
                    end
                end
                RAISE: begin
                    // Mask writes are not consulted here: a raised request
                    // always runs to completion.
                    if (CPU_IRQ_ACK) begin
                        cpu_raise_q <= 1'b0;
                        src_ack_q   <= ack_onehot;
                        state_q     <= ACK;
                    end
                end
                ACK: begin
                    state_q <= SERVICE;
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign CPU_IRQ_RAISE = cpu_raise_q;
    assign SRC_IRQ_ACK   = src_ack_q;

    // ------------------------------------------------------------ bus read
    always_comb begin
        rd_data = '0;
        case (rd_off_q)
            OFF_PEND: rd_data[NumSources-1:0] = pend_q;
            OFF_MASK: rd_data = mask_q;
            OFF_ID:   rd_data = {in_service, 4'b0000, active_id_q};
            default:  rd_data = '0;
        endcase
    end

    // Address was registered last cycle; the current BUS_WE gates the drive so
    // the controller never fights a master that has started a write.
    assign BUS_DATA = (rd_sel_q && !BUS_WE) ? rd_data : 8'hZZ;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Self-checking bench for irq_controller (NumSources=4, BaseAddr=8'hE0).
// A vector table exercises the register window and pending capture/clear;
// hand-written sequences cover dispatch, priority, masking, service hold and
// reset while an interrupt is raised.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    logic       CLK = 1'b0;
    logic       RESET;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic [3:0] SRC_IRQ_RAISE;
    logic [3:0] SRC_IRQ_ACK;
    logic       CPU_IRQ_RAISE;
    logic       CPU_IRQ_ACK;

    logic [7:0] bus_drv;
    logic       bus_oe;
    assign BUS_DATA = bus_oe ? bus_drv : 8'hZZ;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller #(
        .NumSources  (4),
        .BaseAddr    (8'hE0),
        .InitialMask (8'hFF)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_DATA      (BUS_DATA),
        .BUS_ADDR      (BUS_ADDR),
        .BUS_WE        (BUS_WE),
        .SRC_IRQ_RAISE (SRC_IRQ_RAISE),
        .SRC_IRQ_ACK   (SRC_IRQ_ACK),
        .CPU_IRQ_RAISE (CPU_IRQ_RAISE),
        .CPU_IRQ_ACK   (CPU_IRQ_ACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] src;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All stimulus changes and samples happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        BUS_ADDR = addr;
        bus_drv  = data;
        bus_oe   = 1'b1;
        BUS_WE   = 1'b1;
        tick();
        BUS_WE   = 1'b0;
        bus_oe   = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        BUS_ADDR = addr;
        BUS_WE   = 1'b0;
        tick();
        data     = BUS_DATA;
        BUS_ADDR = 8'h00;
    endtask

    // CPU ack handshake: ack pulse after A0, gone after A1. The source drops
    // its raise once it has seen its ack.
    task automatic do_ack(input string nm, input logic [3:0] exp_ack, input logic [3:0] src_after);
        CPU_IRQ_ACK = 1'b1;
        tick();
        CPU_IRQ_ACK = 1'b0;
        check({nm, " ack pulse"}, {4'h0, SRC_IRQ_ACK}, {4'h0, exp_ack});
        check({nm, " raise low in ACK"}, {7'h0, CPU_IRQ_RAISE}, 8'h00);
        SRC_IRQ_RAISE = src_after;
        tick();
        check({nm, " ack ends"}, {4'h0, SRC_IRQ_ACK}, 8'h00);
    endtask

    logic [7:0] rd;

    initial begin
        // Table: mask programming, window decode, capture, clear, set-wins.
        vecs[0]  = '{1'b1, 8'hE1, 8'h00, 4'b0000, 8'h00};
        vecs[1]  = '{1'b0, 8'hE1, 8'h00, 4'b0000, 8'h00};
        vecs[2]  = '{1'b1, 8'hE5, 8'h5A, 4'b0000, 8'h00};
        vecs[3]  = '{1'b0, 8'hE1, 8'h00, 4'b0000, 8'h00};
        vecs[4]  = '{1'b1, 8'hE1, 8'hA5, 4'b0000, 8'h00};
        vecs[5]  = '{1'b0, 8'hE1, 8'h00, 4'b0000, 8'hA5};
        vecs[6]  = '{1'b1, 8'hE1, 8'h00, 4'b0000, 8'h00};
        vecs[7]  = '{1'b0, 8'hE0, 8'h00, 4'b0101, 8'h05};
        vecs[8]  = '{1'b1, 8'hE3, 8'h01, 4'b0101, 8'h00};
        vecs[9]  = '{1'b0, 8'hE0, 8'h00, 4'b0101, 8'h04};
        vecs[10] = '{1'b0, 8'hE0, 8'h00, 4'b1111, 8'h0E};
        vecs[11] = '{1'b1, 8'hE3, 8'hFF, 4'b0000, 8'h00};
        vecs[12] = '{1'b0, 8'hE0, 8'h00, 4'b0000, 8'h00};
        vecs[13] = '{1'b1, 8'hE3, 8'h02, 4'b0010, 8'h00};
        vecs[14] = '{1'b0, 8'hE0, 8'h00, 4'b0010, 8'h02};
        vecs[15] = '{1'b1, 8'hE3, 8'h02, 4'b0010, 8'h00};
        vecs[16] = '{1'b0, 8'hE0, 8'h00, 4'b0000, 8'h00};
        vecs[17] = '{1'b0, 8'hE2, 8'h00, 4'b0000, 8'h00};
        vecs[18] = '{1'b1, 8'hE1, 8'hFF, 4'b0000, 8'h00};
        vecs[19] = '{1'b0, 8'hE1, 8'h00, 4'b0000, 8'hFF};

        RESET         = 1'b1;
        BUS_ADDR      = 8'h00;
        BUS_WE        = 1'b0;
        bus_drv       = 8'h00;
        bus_oe        = 1'b0;
        SRC_IRQ_RAISE = 4'b0000;
        CPU_IRQ_ACK   = 1'b0;
        tick();
        tick();
        RESET = 1'b0;

        // ---------------- reset values
        check("reset cpu_raise", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        check("reset src_ack", {4'h0, SRC_IRQ_ACK}, 8'h00);
        bus_read(8'hE0, rd); check("reset pending", rd, 8'h00);
        bus_read(8'hE1, rd); check("reset mask", rd, 8'hFF);
        bus_read(8'hE2, rd); check("reset id", rd, 8'h00);

        // ---------------- vector table
        for (int i = 0; i < NV; i++) begin
            SRC_IRQ_RAISE = vecs[i].src;
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d read %h", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end
        check("table no raise", {7'h0, CPU_IRQ_RAISE}, 8'h00);

        // ---------------- single request on source 2
        SRC_IRQ_RAISE = 4'b0100;
        tick();
        check("single raise after E0", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        tick();
        check("single raise after E1", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        bus_read(8'hE2, rd); check("single id in RAISE", rd, 8'h82);
        do_ack("single", 4'b0100, 4'b0000);
        bus_read(8'hE2, rd); check("single id in SERVICE", rd, 8'h82);
        bus_write(8'hE2, 8'h00);
        bus_read(8'hE2, rd); check("single id after EOI", rd, 8'h02);

        // ---------------- priority: sources 3 and 1 together
        SRC_IRQ_RAISE = 4'b1010;
        tick();
        tick();
        check("prio raise", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        bus_read(8'hE0, rd); check("prio pending", rd, 8'h08);
        bus_read(8'hE2, rd); check("prio first id", rd, 8'h81);
        do_ack("prio1", 4'b0010, 4'b1000);
        bus_write(8'hE2, 8'h00);
        check("prio raise at EOI edge", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        tick();
        check("prio second raise", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        bus_read(8'hE2, rd); check("prio second id", rd, 8'h83);
        do_ack("prio3", 4'b1000, 4'b0000);
        bus_write(8'hE2, 8'h00);

        // ---------------- mask
        bus_write(8'hE1, 8'hFE);
        SRC_IRQ_RAISE = 4'b0001;
        tick();
        tick();
        tick();
        check("mask no raise", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        bus_read(8'hE0, rd); check("mask pending", rd, 8'h01);
        bus_write(8'hE1, 8'hFF);
        check("mask raise at write edge", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        tick();
        check("mask raise after unmask", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        do_ack("mask", 4'b0001, 4'b0000);
        bus_write(8'hE2, 8'h00);

        // ---------------- SERVICE hold with another source pending
        SRC_IRQ_RAISE = 4'b0100;
        tick();
        tick();
        check("hold first raise", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        do_ack("hold", 4'b0100, 4'b0001);
        BUS_ADDR = 8'hE2;
        for (int c = 0; c < 100; c++) begin
            tick();
            check($sformatf("hold raise c%0d", c), {7'h0, CPU_IRQ_RAISE}, 8'h00);
            check($sformatf("hold id c%0d", c), BUS_DATA, 8'h82);
        end
        bus_write(8'hE2, 8'h00);
        check("hold raise at EOI edge", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        tick();
        check("hold next raise", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        bus_read(8'hE2, rd); check("hold next id", rd, 8'h80);
        do_ack("hold0", 4'b0001, 4'b0000);
        bus_write(8'hE2, 8'h00);

        // ---------------- reset while in RAISE
        SRC_IRQ_RAISE = 4'b0100;
        tick();
        tick();
        check("rst pre raise", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        RESET = 1'b1;
        tick();
        check("rst raise cleared", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        check("rst no ack", {4'h0, SRC_IRQ_ACK}, 8'h00);
        RESET = 1'b0;
        tick();
        check("rst raise after E0", {7'h0, CPU_IRQ_RAISE}, 8'h00);
        check("rst no ack after E0", {4'h0, SRC_IRQ_ACK}, 8'h00);
        tick();
        check("rst redispatch", {7'h0, CPU_IRQ_RAISE}, 8'h01);
        bus_read(8'hE0, rd); check("rst pending after dispatch", rd, 8'h00);
        do_ack("rst", 4'b0100, 4'b0000);
        bus_write(8'hE2, 8'h00);
        bus_read(8'hE2, rd); check("rst final id", rd, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
